// File: rtl/gpu_pkg.sv
// Shared types for the core control path: core FSM codes, LSU lane states and
// the fetcher "instruction ready" code.
package gpu_pkg;

  typedef enum logic [2:0] {
    CORE_IDLE    = 3'd0,
    CORE_FETCH   = 3'd1,
    CORE_DECODE  = 3'd2,
    CORE_REQUEST = 3'd3,
    CORE_WAIT    = 3'd4,
    CORE_EXECUTE = 3'd5,
    CORE_UPDATE  = 3'd6,
    CORE_DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    LSU_IDLE       = 2'b00,
    LSU_REQUESTING = 2'b01,
    LSU_WAITING    = 2'b10,
    LSU_DONE       = 2'b11
  } lsu_state_t;

  localparam logic [2:0] FETCHER_FETCHED = 3'b010;

  // A lane still owns an outstanding memory access while requesting or waiting.
  function automatic logic lsu_busy(input logic [1:0] s);
    return (s == LSU_REQUESTING) || (s == LSU_WAITING);
  endfunction

endpackage

// File: rtl/warp_pc_select.sv
// Min-PC reduction over one warp's live lanes plus the mask of lanes sitting
// at that PC. With no live lane the PC reads 0 and the mask is empty.
module warp_pc_select #(
  parameter int LANES   = 4,
  parameter int PC_BITS = 8
) (
  input  logic [LANES-1:0][PC_BITS-1:0] i_pc,
  input  logic [LANES-1:0]              i_live,
  output logic [PC_BITS-1:0]            o_min_pc,
  output logic [LANES-1:0]              o_mask
);

  logic [PC_BITS-1:0] w_min;
  logic               w_any;

  always_comb begin
    // NOTE: every variable gets a default before the loops, so no path leaves one unassigned (no latch).
    w_min  = '0;
    w_any  = 1'b0;
    o_mask = '0;
    // NOTE: blocking assignments here so each loop iteration sees the running minimum.
    for (int t = 0; t < LANES; t++) begin
      if (i_live[t] && (!w_any || (i_pc[t] < w_min))) begin
        w_min = i_pc[t];
        w_any = 1'b1;
      end
    end
    for (int t = 0; t < LANES; t++) begin
      o_mask[t] = i_live[t] && (i_pc[t] == w_min);
    end
  end

  assign o_min_pc = w_any ? w_min : '0;

endmodule

// File: rtl/warp_scheduler.sv
// Per-core warp scheduler: core FSM, per-thread PC/live tracking and round-robin
// warp switching. Define WARP_DIVERGENCE_EN for per-thread PCs with min-PC reconvergence.
module warp_scheduler
  import gpu_pkg::*;
#(
  parameter  int NUM_WARPS        = 4,
  parameter  int THREADS_PER_WARP = 4,
  parameter  int PC_BITS          = 8,
  localparam int TC_BITS          = $clog2(NUM_WARPS * THREADS_PER_WARP) + 1,
  localparam int WARP_BITS        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [TC_BITS-1:0]                        thread_count,
  input  logic [2:0]                                fetcher_state,
  input  logic                                      decoded_mem_read_enable,
  input  logic                                      decoded_mem_write_enable,
  input  logic                                      decoded_ret,
  input  logic [THREADS_PER_WARP-1:0][1:0]          lsu_state,
  input  logic [THREADS_PER_WARP-1:0][PC_BITS-1:0]  next_pc,
  output logic [2:0]                                core_state,
  output logic [PC_BITS-1:0]                        current_pc,
  output logic [WARP_BITS-1:0]                      active_warp,
  output logic [THREADS_PER_WARP-1:0]               thread_mask,
  output logic                                      done
);

  localparam int T = THREADS_PER_WARP;

  core_state_t                   r_state;
  core_state_t                   w_state_next;
  logic [WARP_BITS-1:0]          r_active_warp;
  logic [WARP_BITS-1:0]          w_next_warp;
  logic                          w_found;
  logic [NUM_WARPS-1:0][T-1:0]   r_live;
  logic [T-1:0]                  w_live_cur;
  logic [T-1:0]                  w_mask;
  logic [T-1:0]                  w_kill;
  logic [T-1:0][PC_BITS-1:0]     w_lane_pc;
  logic [PC_BITS-1:0]            w_cur_pc;
  logic [NUM_WARPS-1:0]          w_warp_alive;
  logic                          w_lsu_busy;
  logic                          w_is_mem;

`ifdef WARP_DIVERGENCE_EN
  logic [NUM_WARPS-1:0][T-1:0][PC_BITS-1:0] r_pc;
  assign w_lane_pc = r_pc[r_active_warp];
`else
  // Single PC per warp: every lane presents the warp PC, so the mask is all live lanes.
  logic [NUM_WARPS-1:0][PC_BITS-1:0] r_pc;
  logic [PC_BITS-1:0]                w_last_pc;
  assign w_lane_pc = {T{r_pc[r_active_warp]}};

  always_comb begin
    w_last_pc = '0;
    for (int t = 0; t < T; t++) begin
      if (w_mask[t]) w_last_pc = next_pc[t];
    end
  end
`endif

  assign w_live_cur = r_live[r_active_warp];

  warp_pc_select #(
    .LANES   (T),
    .PC_BITS (PC_BITS)
  ) u_pc_select (
    .i_pc     (w_lane_pc),
    .i_live   (w_live_cur),
    .o_min_pc (w_cur_pc),
    .o_mask   (w_mask)
  );

  assign w_kill   = decoded_ret ? w_mask : '0;
  assign w_is_mem = decoded_mem_read_enable || decoded_mem_write_enable;

  always_comb begin
    w_lsu_busy = 1'b0;
    for (int t = 0; t < T; t++) begin
      if (w_mask[t] && lsu_busy(lsu_state[t])) w_lsu_busy = 1'b1;
    end
  end

  // Liveness as it will be after this UPDATE, so a warp retiring now is skipped.
  always_comb begin
    w_warp_alive = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (WARP_BITS'(w) == r_active_warp) w_warp_alive[w] = |(r_live[w] & ~w_kill);
      else                                w_warp_alive[w] = |r_live[w];
    end
  end

  always_comb begin
    w_found     = 1'b0;
    w_next_warp = r_active_warp;
    for (int k = 1; k <= NUM_WARPS; k++) begin
      if (!w_found && w_warp_alive[WARP_BITS'((int'(r_active_warp) + k) % NUM_WARPS)]) begin
        w_found     = 1'b1;
        w_next_warp = WARP_BITS'((int'(r_active_warp) + k) % NUM_WARPS);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      CORE_IDLE:    if (start) w_state_next = (thread_count == '0) ? CORE_DONE : CORE_FETCH;
      CORE_FETCH:   if (fetcher_state == FETCHER_FETCHED) w_state_next = CORE_DECODE;
      CORE_DECODE:  w_state_next = CORE_REQUEST;
      CORE_REQUEST: w_state_next = CORE_WAIT;
      CORE_WAIT:    if (!(w_is_mem && w_lsu_busy)) w_state_next = CORE_EXECUTE;
      CORE_EXECUTE: w_state_next = CORE_UPDATE;
      CORE_UPDATE:  w_state_next = w_found ? CORE_FETCH : CORE_DONE;
      CORE_DONE:    w_state_next = CORE_DONE;
      default:      w_state_next = CORE_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= CORE_IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the PC array is a handful of flops that must read 0 out of reset, so it is reset like any register.
      r_active_warp <= '0;
      r_live        <= '0;
      r_pc          <= '0;
    end else if ((r_state == CORE_IDLE) && start) begin
      r_active_warp <= '0;
      r_pc          <= '0;
      for (int w = 0; w < NUM_WARPS; w++) begin
        for (int t = 0; t < T; t++) begin
          r_live[w][t] <= ((w * T + t) < int'(thread_count));
        end
      end
    end else if (r_state == CORE_UPDATE) begin
      r_active_warp <= w_next_warp;
`ifdef WARP_DIVERGENCE_EN
      for (int t = 0; t < T; t++) begin
        if (w_mask[t]) begin
          if (decoded_ret) r_live[r_active_warp][t] <= 1'b0;
          else             r_pc[r_active_warp][t]   <= next_pc[t];
        end
      end
`else
      if (decoded_ret) r_live[r_active_warp] <= '0;
      else             r_pc[r_active_warp]   <= w_last_pc;
`endif
    end
  end

  assign core_state  = r_state;
  assign current_pc  = w_cur_pc;
  assign active_warp = r_active_warp;
  assign thread_mask = w_mask;
  assign done        = (r_state == CORE_DONE);

endmodule

// File: tb/tb_warp_scheduler.sv
// Self-checking bench for warp_scheduler: directed scenarios plus randomized
// programs checked against a thread-level reference model.
module tb_warp_scheduler;
  import gpu_pkg::*;

  localparam int NW  = 4;
  localparam int T   = 4;
  localparam int PCB = 8;
  localparam int TCB = 5;
  localparam int WB  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [TCB-1:0]      thread_count;
  logic [2:0]          fetcher_state;
  logic                mem_rd, mem_wr, ret;
  logic [T-1:0][1:0]   lsu_state;
  logic [T-1:0][PCB-1:0] next_pc;
  logic [2:0]          core_state;
  logic [PCB-1:0]      current_pc;
  logic [WB-1:0]       active_warp;
  logic [T-1:0]        thread_mask;
  logic                done;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model: one PC and one live bit per thread, plus the active warp.
  int m_pc   [NW][T];
  bit m_live [NW][T];
  int m_aw;

  warp_scheduler #(
    .NUM_WARPS        (NW),
    .THREADS_PER_WARP (T),
    .PC_BITS          (PCB)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .start                    (start),
    .thread_count             (thread_count),
    .fetcher_state            (fetcher_state),
    .decoded_mem_read_enable  (mem_rd),
    .decoded_mem_write_enable (mem_wr),
    .decoded_ret              (ret),
    .lsu_state                (lsu_state),
    .next_pc                  (next_pc),
    .core_state               (core_state),
    .current_pc               (current_pc),
    .active_warp              (active_warp),
    .thread_mask              (thread_mask),
    .done                     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_warp_any(input int w);
    bit a = 1'b0;
    for (int t = 0; t < T; t++) a |= m_live[w][t];
    return a;
  endfunction

  function automatic bit m_any();
    bit a = 1'b0;
    for (int w = 0; w < NW; w++) a |= m_warp_any(w);
    return a;
  endfunction

  function automatic int m_cur_pc();
    int best = -1;
    for (int t = 0; t < T; t++)
      if (m_live[m_aw][t] && (best < 0 || m_pc[m_aw][t] < best)) best = m_pc[m_aw][t];
    return (best < 0) ? 0 : best;
  endfunction

  function automatic logic [T-1:0] m_mask();
    logic [T-1:0] mk;
    int pc;
    pc = m_cur_pc();
    for (int t = 0; t < T; t++) mk[t] = m_live[m_aw][t] && (m_pc[m_aw][t] == pc);
    return mk;
  endfunction

  task automatic m_clear();
    for (int w = 0; w < NW; w++)
      for (int t = 0; t < T; t++) begin
        m_pc[w][t]   = 0;
        m_live[w][t] = 1'b0;
      end
    m_aw = 0;
  endtask

  task automatic m_launch(input int tc);
    m_clear();
    for (int w = 0; w < NW; w++)
      for (int t = 0; t < T; t++) m_live[w][t] = ((w * T + t) < tc);
  endtask

  task automatic m_update(input bit kill, input logic [T-1:0][PCB-1:0] npc);
    logic [T-1:0] mk;
    int hi;
    mk = m_mask();
    hi = 0;
    for (int t = 0; t < T; t++) if (mk[t]) hi = t;
    for (int t = 0; t < T; t++) begin
`ifdef WARP_DIVERGENCE_EN
      if (mk[t]) begin
        if (kill) m_live[m_aw][t] = 1'b0;
        else      m_pc[m_aw][t]   = int'(npc[t]);
      end
`else
      if (m_live[m_aw][t]) begin
        if (kill) m_live[m_aw][t] = 1'b0;
        else      m_pc[m_aw][t]   = int'(npc[hi]);
      end
`endif
    end
    for (int k = 1; k <= NW; k++) begin
      if (m_warp_any((m_aw + k) % NW)) begin
        m_aw = (m_aw + k) % NW;
        break;
      end
    end
  endtask

  // Lanes in the current group advance by 1..max_inc; other lanes get junk that must be ignored.
  function automatic logic [T-1:0][PCB-1:0] npc_step(input int max_inc);
    logic [T-1:0]          mk;
    logic [T-1:0][PCB-1:0] r;
    mk = m_mask();
    for (int t = 0; t < T; t++)
      r[t] = mk[t] ? PCB'(m_pc[m_aw][t] + int'($urandom_range(1, max_inc))) : PCB'($urandom_range(0, 255));
    return r;
  endfunction

  task automatic idle_inputs();
    start = 1'b0; fetcher_state = 3'b000;
    mem_rd = 1'b0; mem_wr = 1'b0; ret = 1'b0;
    lsu_state = '0; next_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);
    check("rst_state", core_state, CORE_IDLE);
    check("rst_done", done, 0);
    check("rst_mask", thread_mask, 0);
    check("rst_pc", current_pc, 0);
    check("rst_warp", active_warp, 0);
    reset = 1'b0;
    m_clear();
  endtask

  task automatic launch(input int tc);
    thread_count = TCB'(tc);
    start = 1'b1;
    m_launch(tc);
    @(negedge clk);
    start = 1'b0;
    check("launch_state", core_state, m_any() ? CORE_FETCH : CORE_DONE);
    check("launch_done", done, !m_any());
  endtask

  task automatic run_instr(input bit is_ld, input bit is_st, input bit is_ret, input int wait_n,
                           input logic [T-1:0] busy_lanes, input logic [T-1:0][PCB-1:0] npc);
    logic [T-1:0] exp_mask;
    int exp_pc, budget;
    bit is_mem;
    is_mem = is_ld || is_st;
    budget = 0;
    while (core_state != CORE_FETCH && core_state != CORE_DONE && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    check("fetch_state", core_state, CORE_FETCH);
    exp_pc   = m_cur_pc();
    exp_mask = m_mask();
    check("fetch_warp", active_warp, m_aw);
    check("fetch_pc", current_pc, exp_pc);
    check("fetch_mask", thread_mask, exp_mask);
    check("mask_nonempty", |thread_mask, 1);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("fetch_hold", core_state, CORE_FETCH);
    end
    fetcher_state = FETCHER_FETCHED;
    mem_rd = is_ld; mem_wr = is_st; ret = is_ret;
    @(negedge clk);
    fetcher_state = 3'b000;
    check("decode", core_state, CORE_DECODE);
    @(negedge clk);
    check("request", core_state, CORE_REQUEST);
    if ((busy_lanes & exp_mask) == '0) busy_lanes = exp_mask;
    for (int t = 0; t < T; t++) begin
      if (!exp_mask[t])   lsu_state[t] = 2'($urandom_range(0, 3));
      else if (!is_mem)   lsu_state[t] = LSU_IDLE;
      else if (busy_lanes[t]) lsu_state[t] = LSU_WAITING;
      else                lsu_state[t] = LSU_DONE;
    end
    for (int i = 1; i <= wait_n; i++) begin
      @(negedge clk);
      check("wait", core_state, CORE_WAIT);
      if (i == wait_n)
        for (int t = 0; t < T; t++) if (exp_mask[t] && is_mem) lsu_state[t] = LSU_DONE;
    end
    @(negedge clk);
    check("execute", core_state, CORE_EXECUTE);
    next_pc = npc;
    @(negedge clk);
    check("update", core_state, CORE_UPDATE);
    check("update_pc", current_pc, exp_pc);
    check("update_mask", thread_mask, exp_mask);
    m_update(is_ret, npc);
    @(negedge clk);
    lsu_state = '0; mem_rd = 1'b0; mem_wr = 1'b0; ret = 1'b0;
    check("next_state", core_state, m_any() ? CORE_FETCH : CORE_DONE);
    check("next_done", done, !m_any());
  endtask

  task automatic prog1();
    launch(4);
    run_instr(0, 0, 0, 1, '0, npc_step(1));
    run_instr(1, 0, 0, 3, 4'b1010, npc_step(1));
    run_instr(0, 0, 1, 1, '0, npc_step(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 24 && m_any(); i++) run_instr(0, 0, 1, 1, '0, npc_step(1));
  endtask

  task automatic start_ignored();
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("done_hold_state", core_state, CORE_DONE);
    check("done_hold_flag", done, 1);
    check("done_mask", thread_mask, 0);
    start = 1'b0;
  endtask

  initial begin
    logic [T-1:0][PCB-1:0] v;
    thread_count = '0;
    do_reset();

    // Single-warp three-instruction program.
    prog1();
    start_ignored();

    // Two warps (6 threads): alternation between warp 0 and the half-full warp 1.
    do_reset();
    launch(6);
    repeat (4) run_instr(0, 0, 0, 1, '0, npc_step(1));
    drain();

    // Divergent branch: lanes 0-1 jump to 8, lanes 2-3 to 5, then step until merged.
    do_reset();
    launch(4);
    v[0] = 8'd8; v[1] = 8'd8; v[2] = 8'd5; v[3] = 8'd5;
    run_instr(0, 0, 0, 1, '0, v);
    repeat (4) run_instr(0, 0, 0, 1, '0, npc_step(1));
    drain();

    // Load with lane 2 waiting seven cycles.
    do_reset();
    launch(4);
    run_instr(1, 0, 0, 7, 4'b0100, npc_step(1));
    run_instr(0, 1, 0, 2, 4'b0001, npc_step(1));
    drain();

    // Warp 0 retires while warp 1 keeps running.
    do_reset();
    launch(8);
    run_instr(0, 0, 1, 1, '0, npc_step(1));
    repeat (3) run_instr(0, 0, 0, 1, '0, npc_step(1));
    drain();
    start_ignored();

    // Asynchronous reset while in WAIT, then the first program again.
    do_reset();
    launch(4);
    fetcher_state = FETCHER_FETCHED; mem_rd = 1'b1;
    @(negedge clk); fetcher_state = 3'b000;
    @(negedge clk); lsu_state = {T{LSU_WAITING}};
    @(negedge clk);
    check("pre_reset_wait", core_state, CORE_WAIT);
    #2 reset = 1'b1;
    #1;
    check("async_rst_state", core_state, CORE_IDLE);
    check("async_rst_done", done, 0);
    check("async_rst_mask", thread_mask, 0);
    check("async_rst_pc", current_pc, 0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    m_clear();
    prog1();

    // Randomized programs, including empty and over-full thread counts.
    for (int r = 0; r < 6; r++) begin
      int tc, n;
      bit k_ret, k_mem, k_st;
      int wn;
      do_reset();
      case (r)
        0:       tc = 0;
        1:       tc = 1;
        2:       tc = 16;
        3:       tc = 20;
        default: tc = int'($urandom_range(2, 15));
      endcase
      launch(tc);
      n = 0;
      while (m_any() && n < 60) begin
        k_ret = (n >= 20) || ($urandom_range(0, 5) == 0);
        k_mem = !k_ret && ($urandom_range(0, 2) == 0);
        k_st  = k_mem && ($urandom_range(0, 1) == 1);
        wn    = k_mem ? int'($urandom_range(1, 5)) : 1;
        run_instr(k_mem && !k_st, k_st, k_ret, wn, T'($urandom_range(0, 15)), npc_step(3));
        n++;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
